// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional feature macro: MULDIV_UNSIGNED_EN (adds MULTU/DIVU support).
package muldiv_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } seqState_e;

   // Encoding of the op request bit
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Default operand width; one shift-add / restoring step per operand bit
   localparam int ITER = 32;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the control unit and the mult/div sequencer.
// With MULDIV_UNSIGNED_EN defined the bundle also carries the uns select.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef MULDIV_UNSIGNED_EN
   logic             uns;
`endif
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

`ifdef MULDIV_UNSIGNED_EN
   modport master (
      output start, op, a, b, uns,
      input  busy, done, div_zero, hi, lo
   );
   modport slave (
      input  start, op, a, b, uns,
      output busy, done, div_zero, hi, lo
   );
`else
   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );
   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
`endif

endinterface

// File: rtl/muldiv_datapath.sv
// Arithmetic datapath of the mult/div sequencer: magnitude load, one
// shift-add or restoring-divide step per strobe, and sign fix-up of the result.
// Signedness comes in through uns (tied low when MULDIV_UNSIGNED_EN is not defined).
module muldiv_datapath
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             stepMult,
   input  logic             stepDiv,
   input  logic             fix,
   input  logic             uns,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] fixHi,
   output logic [WIDTH-1:0] fixLo
);

   // accHiReg: upper product half / partial remainder
   // accLoReg: multiplier bits still to consume / dividend bits -> quotient bits
   // mdReg:    multiplicand magnitude (MULT) or divisor magnitude (DIV)
   logic [WIDTH-1:0]   accHiReg;
   logic [WIDTH-1:0]   accLoReg;
   logic [WIDTH-1:0]   mdReg;
   logic               opReg;
   logic               signAReg;
   logic               signBReg;

   logic               signA;
   logic               signB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     multSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] productNeg;

   // Operand signs and magnitudes; unsigned requests bypass the conversion
   always_comb begin
      signA = ~uns & a[WIDTH-1];
      signB = ~uns & b[WIDTH-1];
      magA  = signA ? -a : a;
      magB  = signB ? -b : b;
   end

   // Single-step arithmetic: shift-add sum and restoring trial subtraction
   always_comb begin
      multSum  = {1'b0, accHiReg} + {1'b0, mdReg & {WIDTH{accLoReg[0]}}};
      divShift = {accHiReg, accLoReg[WIDTH-1]};
      divDiff  = divShift - {1'b0, mdReg};
   end

   // Load, step and post-result scrub of the working registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         accHiReg <= '0;
         accLoReg <= '0;
         mdReg    <= '0;
         opReg    <= OP_MULT;
         signAReg <= 1'b0;
         signBReg <= 1'b0;
      end else if (load) begin
         opReg    <= op;
         signAReg <= signA;
         signBReg <= signB;
         accHiReg <= '0;
         accLoReg <= (op == OP_DIV) ? magA : magB;
         mdReg    <= (op == OP_DIV) ? magB : magA;
      end else if (stepMult) begin
         // shift the (WIDTH+1)-bit sum right through the accumulator
         accHiReg <= multSum[WIDTH:1];
         accLoReg <= {multSum[0], accLoReg[WIDTH-1:1]};
      end else if (stepDiv) begin
         // borrow bit clear means the divisor fits: keep difference, quotient bit 1
         if (!divDiff[WIDTH]) begin
            accHiReg <= divDiff[WIDTH-1:0];
            accLoReg <= {accLoReg[WIDTH-2:0], 1'b1};
         end else begin
            accHiReg <= divShift[WIDTH-1:0];
            accLoReg <= {accLoReg[WIDTH-2:0], 1'b0};
         end
      end else if (fix) begin
         // result is captured into HI/LO on this edge, so the datapath is cleared
         accHiReg <= '0;
         accLoReg <= '0;
         mdReg    <= '0;
         signAReg <= 1'b0;
         signBReg <= 1'b0;
      end
   end

   // Sign fix-up: product negated on mixed signs; quotient takes sign(a)^sign(b),
   // remainder takes sign(a) (truncating division)
   always_comb begin
      product    = {accHiReg, accLoReg};
      productNeg = -product;
      fixHi      = accHiReg;
      fixLo      = accLoReg;
      if (opReg == OP_DIV) begin
         fixLo = (signAReg ^ signBReg) ? -accLoReg : accLoReg;
         fixHi = signAReg ? -accHiReg : accHiReg;
      end else if (signAReg ^ signBReg) begin
         fixHi = productNeg[2*WIDTH-1:WIDTH];
         fixLo = productNeg[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle HI/LO multiply/divide sequencer: FSM, iteration counter and
// the HI/LO result registers. Optional macro MULDIV_UNSIGNED_EN adds the uns
// select for MULTU/DIVU; latency is the same for signed and unsigned requests.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input logic               clk,
   input logic               reset,
   muldiv_sequencer_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   seqState_e        stateReg;
   seqState_e        stateNext;
   logic [CNT_W-1:0] cntReg;
   logic [CNT_W-1:0] cntNext;
   logic [WIDTH-1:0] hiReg;
   logic [WIDTH-1:0] loReg;
   logic             busyReg;
   logic             doneReg;
   logic             divZeroReg;
   logic             divZeroNext;

   logic             load;
   logic             stepMult;
   logic             stepDiv;
   logic             fix;
   logic             unsSel;
   logic [WIDTH-1:0] fixHi;
   logic [WIDTH-1:0] fixLo;

`ifdef MULDIV_UNSIGNED_EN
   assign unsSel = bus.uns;
`else
   assign unsSel = 1'b0;
`endif

   muldiv_datapath #(
      .WIDTH (WIDTH)
   ) datapath (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .stepMult (stepMult),
      .stepDiv  (stepDiv),
      .fix      (fix),
      .uns      (unsSel),
      .op       (bus.op),
      .a        (bus.a),
      .b        (bus.b),
      .fixHi    (fixHi),
      .fixLo    (fixLo)
   );

   // Next-state, counter and datapath strobes; requests are only honoured in IDLE
   always_comb begin
      stateNext   = stateReg;
      cntNext     = cntReg;
      load        = 1'b0;
      stepMult    = 1'b0;
      stepDiv     = 1'b0;
      fix         = 1'b0;
      divZeroNext = 1'b0;
      case (stateReg)
         IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_DIV && bus.b == '0) begin
                  // divide by zero skips the datapath, HI/LO stay untouched
                  stateNext   = DONE;
                  divZeroNext = 1'b1;
               end else begin
                  load      = 1'b1;
                  cntNext   = CNT_W'(WIDTH - 1);
                  stateNext = (bus.op == OP_DIV) ? DIV : MULT;
               end
            end
         end
         MULT: begin
            stepMult = 1'b1;
            if (cntReg == '0) stateNext = FIX;
            else              cntNext   = cntReg - 1'b1;
         end
         DIV: begin
            stepDiv = 1'b1;
            if (cntReg == '0) stateNext = FIX;
            else              cntNext   = cntReg - 1'b1;
         end
         FIX: begin
            fix       = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, counter and registered status flags (derived from the next state)
   always_ff @(posedge clk) begin
      if (!reset) begin
         stateReg   <= IDLE;
         cntReg     <= '0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         divZeroReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         cntReg     <= cntNext;
         busyReg    <= (stateNext != IDLE);
         doneReg    <= (stateNext == DONE);
         divZeroReg <= divZeroNext;
      end
   end

   // HI/LO capture the sign-fixed result only when leaving FIX
   always_ff @(posedge clk) begin
      if (!reset) begin
         hiReg <= '0;
         loReg <= '0;
      end else if (fix) begin
         hiReg <= fixHi;
         loReg <= fixLo;
      end
   end

   assign bus.busy     = busyReg;
   assign bus.done     = doneReg;
   assign bus.div_zero = divZeroReg;
   assign bus.hi       = hiReg;
   assign bus.lo       = loReg;

endmodule
